// File: rtl/uart_priemnik.sv
// uart_priemnik: 8N1 serial receive front end for the terminal-input path.
//
// Deserialises an asynchronous line into bytes and hands each good byte to the
// downstream decoder with a fixed-width strobe.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   Reset      synchronous, active-high reset
//   rx_in      asynchronous serial line, idle high
//   data_out   last correctly framed byte, held until the next good frame
//   priem      high for STROBE_CYCLES cycles after each good frame
//   frame_err  one-cycle pulse when the stop bit samples low
//   busy       high from start-bit detection until the FSM is back in IDLE
module uart_priemnik #(
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       priem,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);

    // The IDLE cycle that first sees rx_s low counts as the first cycle of the
    // start bit, so the mid-bit sample is taken when cnt reaches HALF-2.
    localparam logic [CW-1:0] HALF_M2 = CW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] STRB_LD = SW'(STROBE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shadow_q, shadow_d;
    logic [7:0]      data_q, data_d;
    logic            pend_q, pend_d;
    logic [SW-1:0]   strb_q, strb_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            cnt_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            strb_q   <= '0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            strb_q   <= strb_d;
            ferr_q   <= ferr_d;
        end
    end

    // Strobe counter runs independently of the FSM so a new frame can start
    // while the previous strobe is still high.
    always_comb begin
        strb_d = strb_q;
        if (pend_q) begin
            strb_d = STRB_LD;
        end else if (strb_q != '0) begin
            strb_d = strb_q - SW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        sync1_d  = rx_in;
        sync2_d  = sync1_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        pend_d   = 1'b0;
        ferr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M2) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    shadow_d = {rx_s, shadow_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shadow_q;
                        pend_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out  = data_q;
    assign priem     = (strb_q != '0);
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_priemnik.sv
// Directed bench for uart_priemnik with CLKS_PER_BIT=8, STROBE_CYCLES=2.
// A negedge monitor logs priem, frame_err and busy pulses (edge index of the
// rise, pulse width, data_out at the rise); each test task checks those logs
// against hand-computed values.
module tb_uart_priemnik;

    logic       clk;
    logic       Reset;
    logic       rx_in;
    logic [7:0] data_out;
    logic       priem;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int rise_q[$];
    int data_q[$];
    int len_q[$];
    int ferr_rise_q[$];
    int ferr_len_q[$];
    int busy_rise_q[$];
    int busy_len_q[$];

    uart_priemnik #(
        .CLKS_PER_BIT (8),
        .STROBE_CYCLES(2)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .rx_in    (rx_in),
        .data_out (data_out),
        .priem    (priem),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Pulse logger, sampled on the falling edge.
    initial begin
        logic p_prev, f_prev, b_prev;
        int   p_run, f_run, b_run;
        p_prev = 1'b0; f_prev = 1'b0; b_prev = 1'b0;
        p_run = 0; f_run = 0; b_run = 0;
        forever begin
            @(negedge clk);
            if (priem === 1'b1 && p_prev == 1'b0) begin
                rise_q.push_back(cyc);
                data_q.push_back(int'(data_out));
                p_run = 0;
            end
            if (priem === 1'b1) p_run = p_run + 1;
            if (priem !== 1'b1 && p_prev == 1'b1) len_q.push_back(p_run);
            p_prev = (priem === 1'b1);

            if (frame_err === 1'b1 && f_prev == 1'b0) begin
                ferr_rise_q.push_back(cyc);
                f_run = 0;
            end
            if (frame_err === 1'b1) f_run = f_run + 1;
            if (frame_err !== 1'b1 && f_prev == 1'b1) ferr_len_q.push_back(f_run);
            f_prev = (frame_err === 1'b1);

            if (busy === 1'b1 && b_prev == 1'b0) begin
                busy_rise_q.push_back(cyc);
                b_run = 0;
            end
            if (busy === 1'b1) b_run = b_run + 1;
            if (busy !== 1'b1 && b_prev == 1'b1) busy_len_q.push_back(b_run);
            b_prev = (busy === 1'b1);
        end
    end

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        rise_q.delete();
        data_q.delete();
        len_q.delete();
        ferr_rise_q.delete();
        ferr_len_q.delete();
        busy_rise_q.delete();
        busy_len_q.delete();
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one full 8N1 frame with no trailing idle; t0 is the edge that
    // captures the start bit into the first synchroniser flop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        rx_in = 1'b0;
        t0    = cyc + 1;
        wait_cycles(8);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            wait_cycles(8);
        end
        rx_in = stop_bit;
        wait_cycles(8);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        rx_in = 1'b1;
        wait_cycles(3);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (priem !== 1'b0) begin errors++; $display("FAIL reset_priem: got %b expected 0", priem); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        Reset = 1'b0;
        wait_cycles(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        clear_logs();
    endtask

    task automatic test_single_frame();
        int t0;
        clear_logs();
        send_frame(8'h1B, 1'b1, t0);
        wait_cycles(6);
        checks++; if (rise_q.size() !== 1) begin errors++; $display("FAIL single_priem_count: got %0d expected 1", rise_q.size()); end
        checks++; if (qget(rise_q, 0) !== t0 + 78) begin errors++; $display("FAIL single_priem_time: got %0d expected %0d", qget(rise_q, 0), t0 + 78); end
        checks++; if (qget(len_q, 0) !== 2) begin errors++; $display("FAIL single_priem_width: got %0d expected 2", qget(len_q, 0)); end
        checks++; if (qget(data_q, 0) !== 32'h1B) begin errors++; $display("FAIL single_data_at_priem: got %h expected 1b", qget(data_q, 0)); end
        checks++; if (data_out !== 8'h1B) begin errors++; $display("FAIL single_data_out: got %h expected 1b", data_out); end
        checks++; if (ferr_rise_q.size() !== 0) begin errors++; $display("FAIL single_frame_err: got %0d pulses expected 0", ferr_rise_q.size()); end
        checks++; if (qget(busy_rise_q, 0) !== t0 + 2) begin errors++; $display("FAIL single_busy_rise: got %0d expected %0d", qget(busy_rise_q, 0), t0 + 2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int         t0s   [4];
        bytes[0] = 8'h1B; bytes[1] = 8'h5B; bytes[2] = 8'h33; bytes[3] = 8'h7E;
        clear_logs();
        for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1, t0s[i]);
        wait_cycles(6);
        checks++; if (rise_q.size() !== 4) begin errors++; $display("FAIL b2b_priem_count: got %0d expected 4", rise_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (qget(rise_q, i) !== t0s[i] + 78) begin errors++; $display("FAIL b2b_priem_time[%0d]: got %0d expected %0d", i, qget(rise_q, i), t0s[i] + 78); end
            checks++; if (qget(data_q, i) !== int'(bytes[i])) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, qget(data_q, i), bytes[i]); end
            checks++; if (qget(len_q, i) !== 2) begin errors++; $display("FAIL b2b_priem_width[%0d]: got %0d expected 2", i, qget(len_q, i)); end
        end
        checks++; if (ferr_rise_q.size() !== 0) begin errors++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", ferr_rise_q.size()); end
    endtask

    task automatic test_frame_error();
        int t0;
        clear_logs();
        send_frame(8'hA5, 1'b0, t0);
        wait_cycles(40);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held_low: got %b expected 1", busy); end
        rx_in = 1'b1;
        wait_cycles(6);
        checks++; if (ferr_rise_q.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_rise_q.size()); end
        checks++; if (qget(ferr_rise_q, 0) !== t0 + 77) begin errors++; $display("FAIL ferr_time: got %0d expected %0d", qget(ferr_rise_q, 0), t0 + 77); end
        checks++; if (qget(ferr_len_q, 0) !== 1) begin errors++; $display("FAIL ferr_width: got %0d expected 1", qget(ferr_len_q, 0)); end
        checks++; if (rise_q.size() !== 0) begin errors++; $display("FAIL ferr_no_priem: got %0d pulses expected 0", rise_q.size()); end
        checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL ferr_data_kept: got %h expected 7e", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_glitch();
        int t0;
        clear_logs();
        rx_in = 1'b0;
        t0    = cyc + 1;
        wait_cycles(3);
        rx_in = 1'b1;
        wait_cycles(15);
        checks++; if (busy_rise_q.size() !== 1) begin errors++; $display("FAIL glitch_busy_count: got %0d expected 1", busy_rise_q.size()); end
        checks++; if (qget(busy_rise_q, 0) !== t0 + 2) begin errors++; $display("FAIL glitch_busy_rise: got %0d expected %0d", qget(busy_rise_q, 0), t0 + 2); end
        checks++; if (qget(busy_len_q, 0) !== 3) begin errors++; $display("FAIL glitch_busy_width: got %0d expected 3", qget(busy_len_q, 0)); end
        checks++; if (rise_q.size() !== 0) begin errors++; $display("FAIL glitch_no_priem: got %0d pulses expected 0", rise_q.size()); end
        checks++; if (ferr_rise_q.size() !== 0) begin errors++; $display("FAIL glitch_no_ferr: got %0d pulses expected 0", ferr_rise_q.size()); end
        checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL glitch_data_kept: got %h expected 7e", data_out); end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        clear_logs();
        rx_in = 1'b0;
        wait_cycles(8);
        rx_in = 1'b1;
        wait_cycles(20);
        Reset = 1'b1;
        wait_cycles(1);
        Reset = 1'b0;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data_out: got %h expected 00", data_out); end
        checks++; if (priem !== 1'b0) begin errors++; $display("FAIL midrst_priem: got %b expected 0", priem); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        wait_cycles(60);
        checks++; if (rise_q.size() !== 0) begin errors++; $display("FAIL midrst_no_priem: got %0d pulses expected 0", rise_q.size()); end
        clear_logs();
        send_frame(8'h08, 1'b1, t0);
        wait_cycles(6);
        checks++; if (rise_q.size() !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", rise_q.size()); end
        checks++; if (qget(rise_q, 0) !== t0 + 78) begin errors++; $display("FAIL midrst_next_time: got %0d expected %0d", qget(rise_q, 0), t0 + 78); end
        checks++; if (data_out !== 8'h08) begin errors++; $display("FAIL midrst_next_data: got %h expected 08", data_out); end
    endtask

    task automatic test_extremes();
        int t0a, t0b;
        clear_logs();
        send_frame(8'h00, 1'b1, t0a);
        wait_cycles(4);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL ext_zero_data_out: got %h expected 00", data_out); end
        send_frame(8'hFF, 1'b1, t0b);
        wait_cycles(6);
        checks++; if (rise_q.size() !== 2) begin errors++; $display("FAIL ext_priem_count: got %0d expected 2", rise_q.size()); end
        checks++; if (qget(data_q, 0) !== 32'h00) begin errors++; $display("FAIL ext_zero_payload: got %h expected 00", qget(data_q, 0)); end
        checks++; if (qget(data_q, 1) !== 32'hFF) begin errors++; $display("FAIL ext_ones_payload: got %h expected ff", qget(data_q, 1)); end
        checks++; if (qget(rise_q, 1) !== t0b + 78) begin errors++; $display("FAIL ext_ones_time: got %0d expected %0d", qget(rise_q, 1), t0b + 78); end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL ext_ones_data_out: got %h expected ff", data_out); end
        checks++; if (ferr_rise_q.size() !== 0) begin errors++; $display("FAIL ext_frame_err: got %0d pulses expected 0", ferr_rise_q.size()); end
    endtask

    initial begin
        Reset = 1'b1;
        rx_in = 1'b1;
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_extremes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop against a hung run; the directed sequence needs ~1200 cycles.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
